// File: rtl/pc_reg_pkg.sv
// Shared CPU constants for the fetch PC slice.
// Defaults: PC width, reset vector, instruction size.
package pc_reg_pkg;

  localparam int          PC_WIDTH        = 32;
  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam int          PC_INSTR_BYTES  = 4;

endpackage

// File: rtl/pc_incr.sv
// Sequential-address incrementer: pc_plus = pc + INSTR_BYTES.
// Ports: pc (in, WIDTH), pc_plus (out, WIDTH); wraps, no carry.
module pc_incr
  import pc_reg_pkg::*;
#(
  parameter int WIDTH       = PC_WIDTH,
  parameter int INSTR_BYTES = PC_INSTR_BYTES
) (
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus
);

  assign pc_plus = pc + WIDTH'(INSTR_BYTES);

endmodule

// File: rtl/pc_reg.sv
// Program counter register with valid flag and alignment check.
// Ports: Clk, Rst(async hi), nextPC -> PC, PCPlus4, PCMisaligned, PCValid.
module pc_reg
  import pc_reg_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter int               INSTR_BYTES  = PC_INSTR_BYTES
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] nextPC,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus4,
  output logic             PCMisaligned,
  output logic             PCValid
);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      PC      <= RESET_VECTOR;
      PCValid <= 1'b0;
    end else begin
      PC      <= nextPC;
      PCValid <= 1'b1;
    end
  end

  pc_incr #(
    .WIDTH       (WIDTH),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_incr (
    .pc      (PC),
    .pc_plus (PCPlus4)
  );

  // Power-of-two sizes reduce to a low-bit mask.
  generate
    if ((INSTR_BYTES & (INSTR_BYTES - 1)) == 0) begin : g_mask
      localparam logic [WIDTH-1:0] MASK = WIDTH'(INSTR_BYTES - 1);
      assign PCMisaligned = |(PC & MASK);
    end else begin : g_mod
      assign PCMisaligned = (PC % WIDTH'(INSTR_BYTES)) != '0;
    end
  endgenerate

endmodule

// File: tb/tb_pc_reg.sv
// Directed self-checking bench for pc_reg.
// 10 ns clock; checks sampled 1 ns after edges or mid-cycle.
module tb_pc_reg;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] nextPC;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        PCMisaligned;
  logic        PCValid;

  int checks = 0;
  int errors = 0;
  logic watch = 1'b0;
  logic seen  = 1'b0;

  pc_reg dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .nextPC       (nextPC),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .PCMisaligned (PCMisaligned),
    .PCValid      (PCValid)
  );

  always #5 Clk = ~Clk;

  always @(PC)
    if (watch && (PC == 32'd16 || PC == 32'd20))
      seen = 1'b1;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst    = 1'b1;
    nextPC = 32'd0;
    #2;
    check("rst_pc",    PC,                  32'd0);
    check("rst_valid", {31'd0, PCValid},    32'd0);
    check("rst_plus",  PCPlus4,             32'd4);
    check("rst_mis",   {31'd0, PCMisaligned}, 32'd0);

    nextPC = 32'h40;
    step();
    step();
    check("hold_pc",    PC,               32'd0);
    check("hold_valid", {31'd0, PCValid}, 32'd0);

    @(negedge Clk);
    Rst    = 1'b0;
    nextPC = 32'd4;
    #1;
    check("rel_pc",    PC,               32'd0);
    check("rel_valid", {31'd0, PCValid}, 32'd0);

    step();
    check("seq4_pc",    PC,               32'd4);
    check("seq4_plus",  PCPlus4,          32'd8);
    check("seq4_valid", {31'd0, PCValid}, 32'd1);
    nextPC = 32'd8;
    step();
    check("seq8_pc",   PC,      32'd8);
    check("seq8_plus", PCPlus4, 32'd12);
    nextPC = 32'd12;
    step();
    check("seq12_pc",   PC,               32'd12);
    check("seq12_plus", PCPlus4,          32'd16);
    check("seq12_valid", {31'd0, PCValid}, 32'd1);

    nextPC = 32'h100;
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("arst_pc",    PC,               32'd0);
    check("arst_valid", {31'd0, PCValid}, 32'd0);
    check("arst_plus",  PCPlus4,          32'd4);
    step();
    check("arst_hold", PC, 32'd0);

    @(negedge Clk);
    Rst    = 1'b0;
    nextPC = 32'hFFFF_FFFC;
    step();
    check("wrap_pc",    PC,                    32'hFFFF_FFFC);
    check("wrap_plus",  PCPlus4,               32'h0000_0000);
    check("wrap_mis",   {31'd0, PCMisaligned}, 32'd0);
    check("wrap_valid", {31'd0, PCValid},      32'd1);

    nextPC = 32'h6;
    step();
    check("mis_pc",   PC,                    32'd6);
    check("mis_flag", {31'd0, PCMisaligned}, 32'd1);
    check("mis_plus", PCPlus4,               32'd10);

    watch  = 1'b1;
    nextPC = 32'd16;
    #2;
    check("mid_a", PC, 32'd6);
    nextPC = 32'd20;
    #2;
    check("mid_b", PC, 32'd6);
    nextPC = 32'd24;
    step();
    check("mid_pc",   PC,      32'd24);
    check("mid_plus", PCPlus4, 32'd28);
    step();
    watch = 1'b0;
    check("mid_seen", {31'd0, seen}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_reg.md
PC_REG -- requirements
Module: pc_reg

Interface
REQ-001 Parameter: WIDTH, default 32, address width of the program counter in bits.
REQ-002 Parameter: RESET_VECTOR, default 32'h0000_0000, value loaded into PC on reset.
REQ-003 Parameter: INSTR_BYTES, default 4, byte size of one instruction, used for the sequential-increment output.
REQ-004 Port: Clk, input, 1, single system clock; all state updates on the rising edge.
REQ-005 Port: Rst, input, 1, asynchronous active-high reset.
REQ-006 Port: nextPC, input, WIDTH, address to load on the next rising clock edge.
REQ-007 Port: PC, output, WIDTH, registered current program counter.
REQ-008 Port: PCPlus4, output, WIDTH, combinational PC + INSTR_BYTES.
REQ-009 Port: PCMisaligned, output, 1, combinational; high when PC is not a multiple of INSTR_BYTES.
REQ-010 Port: PCValid, output, 1, registered; low during reset, high once PC holds a loaded nextPC value.

Function
REQ-011 The block SHALL load PC <= nextPC on every rising Clk edge while Rst is low; there is no enable or stall input.
REQ-012 Load latency SHALL be exactly one clock edge; nextPC changes between edges have no effect on PC.
REQ-013 PC SHALL accept any WIDTH-bit value, including misaligned values, without modification.
REQ-014 PCPlus4 SHALL equal (PC + INSTR_BYTES) modulo 2^WIDTH; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no carry output.
REQ-015 PCMisaligned SHALL equal (PC mod INSTR_BYTES != 0); with INSTR_BYTES = 4 it is the OR of PC[1:0].
REQ-016 PCValid SHALL be 0 while Rst is high and SHALL go to 1 on the first rising Clk edge with Rst low, then stay 1 until the next reset.
REQ-017 All outputs SHALL be free of X once reset has been applied at least once.

Reset
REQ-018 Rst high SHALL force PC = RESET_VECTOR and PCValid = 0 immediately, without waiting for a Clk edge.
REQ-019 While Rst is high, PC SHALL hold RESET_VECTOR and clock edges SHALL be ignored.
REQ-020 If Rst is asserted mid-operation, the PC load in progress SHALL be discarded.
REQ-021 On release of Rst, the first rising edge SHALL load nextPC.
REQ-022 PCPlus4 SHALL reflect RESET_VECTOR + INSTR_BYTES during reset.
REQ-023 PCMisaligned SHALL reflect RESET_VECTOR alignment during reset.

Structure
REQ-024 The following SHALL live in the shared CPU package:
- WIDTH default
- RESET_VECTOR default
- INSTR_BYTES constant
REQ-025 The PC register, valid flag and alignment check SHALL be in pc_reg.
REQ-026 The incrementer SHALL be one sub-module, pc_incr: pure combinational WIDTH-bit add of INSTR_BYTES with wrap.
REQ-027 No latches and no gated clocks SHALL be used.

Verification
REQ-028 The bench SHALL cover these scenarios, with a 10 ns clock:
- Reset/hold: Rst=1, nextPC=0 for 10 ns -> PC=0, PCValid=0, PCPlus4=4, PCMisaligned=0; clock edges do not change PC.
- Sequential load: Rst released, then nextPC=4, 8, 12 applied one per cycle -> PC=4, 8, 12 on successive rising edges; PCPlus4=8, 12, 16; PCValid=1 from the first edge after release.
- Asynchronous reset: PC=12 and Rst pulsed high between edges -> PC=0 immediately (before the next edge) and PCValid=0.
- Wrap-around: nextPC=32'hFFFF_FFFC -> PC=32'hFFFF_FFFC and PCPlus4=32'h0000_0000.
- Misaligned load: nextPC=32'h0000_0006 -> PC=6 after the edge, PCMisaligned=1, PCPlus4=10.
- Mid-cycle nextPC change: nextPC toggles 16 -> 20 -> 24 between two edges -> PC=24 after the edge; 16 and 20 never appear on PC.
